// File: rtl/gpr_wb_arbiter.sv
// Writeback scheduler for the per-warp GPR file: zero-fills every {wid, rd}
// after reset, then merges NUM_REQS writeback sources round-robin into one
// registered writeback port.
module gpr_wb_arbiter #(
  parameter  int NUM_REQS    = 4,
  parameter  int NUM_WARPS   = 4,
  parameter  int NUM_REGS    = 32,
  parameter  int NUM_THREADS = 4,
  parameter  int DATAW       = 32,
  localparam int WIDW        = $clog2(NUM_WARPS),
  localparam int RIDW        = $clog2(NUM_REGS)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_REQS-1:0]                 req_valid_i,
  output logic [NUM_REQS-1:0]                 req_ready_o,
  input  logic [NUM_REQS*WIDW-1:0]            req_wid_i,
  input  logic [NUM_REQS*RIDW-1:0]            req_rd_i,
  input  logic [NUM_REQS*NUM_THREADS-1:0]     req_tmask_i,
  input  logic [NUM_REQS*NUM_THREADS*DATAW-1:0] req_data_i,
  output logic                                wb_valid_o,
  input  logic                                wb_ready_i,
  output logic [WIDW-1:0]                     wb_wid_o,
  output logic [RIDW-1:0]                     wb_rd_o,
  output logic [NUM_THREADS-1:0]              wb_tmask_o,
  output logic [NUM_THREADS*DATAW-1:0]        wb_data_o,
  output logic                                init_busy_o
);

  localparam int PTRW  = $clog2(NUM_REQS);
  localparam int CNTW  = WIDW + RIDW;
  localparam int LANEW = NUM_THREADS * DATAW;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NUM_WARPS * NUM_REGS - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                   state_q;
  logic [CNTW-1:0]          cnt_q;
  logic [PTRW-1:0]          ptr_q;
  logic [PTRW-1:0]          ptr_d;

  logic                     wb_valid_q;
  logic [WIDW-1:0]          wb_wid_q;
  logic [RIDW-1:0]          wb_rd_q;
  logic [NUM_THREADS-1:0]   wb_tmask_q;
  logic [LANEW-1:0]         wb_data_q;

  logic                     load_en;
  logic                     grant_valid;
  logic [PTRW-1:0]          grant_idx;
  logic [WIDW-1:0]          sel_wid;
  logic [RIDW-1:0]          sel_rd;
  logic [NUM_THREADS-1:0]   sel_tmask;
  logic [LANEW-1:0]         sel_data;

  // The output register accepts a new entry whenever it is empty or draining.
  assign load_en = !wb_valid_q || wb_ready_i;

  // Scan offsets from the far end down so the closest valid requester to ptr
  // is the last one written and therefore wins.
  always_comb begin : rr_search
    int              idx;
    logic [PTRW-1:0] idx_b;
    // NOTE: every combinational output gets a default before any branch,
    // otherwise paths that skip the assignment would infer a latch.
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    idx_b       = '0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQS) idx = idx - NUM_REQS;
      idx_b = PTRW'(idx);
      if (req_valid_i[idx_b]) begin
        grant_valid = 1'b1;
        grant_idx   = idx_b;
      end
    end
  end

  always_comb begin : winner_mux
    sel_wid   = req_wid_i[int'(grant_idx)*WIDW +: WIDW];
    sel_rd    = req_rd_i[int'(grant_idx)*RIDW +: RIDW];
    sel_tmask = req_tmask_i[int'(grant_idx)*NUM_THREADS +: NUM_THREADS];
    sel_data  = req_data_i[int'(grant_idx)*LANEW +: LANEW];
    ptr_d     = (int'(grant_idx) == NUM_REQS - 1) ? '0 : grant_idx + 1'b1;
  end

  always_comb begin : ready_gen
    req_ready_o = '0;
    if (state_q == ST_RUN && load_en && grant_valid) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order inside the block.
  // NOTE: the output payload is reset as well, so wb_* reads as zero rather
  // than X until the first sweep entry loads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      ptr_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_wid_q   <= '0;
      wb_rd_q    <= '0;
      wb_tmask_q <= '0;
      wb_data_q  <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (load_en) begin
            wb_valid_q <= 1'b1;
            wb_wid_q   <= cnt_q[CNTW-1 -: WIDW];
            wb_rd_q    <= cnt_q[RIDW-1:0];
            wb_tmask_q <= '1;
            wb_data_q  <= '0;
            cnt_q      <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (load_en) begin
            if (grant_valid) begin
              wb_valid_q <= 1'b1;
              wb_wid_q   <= sel_wid;
              wb_rd_q    <= sel_rd;
              wb_tmask_q <= sel_tmask;
              wb_data_q  <= sel_data;
              ptr_q      <= ptr_d;
            end else begin
              wb_valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign wb_valid_o  = wb_valid_q;
  assign wb_wid_o    = wb_wid_q;
  assign wb_rd_o     = wb_rd_q;
  assign wb_tmask_o  = wb_tmask_q;
  assign wb_data_o   = wb_data_q;
  assign init_busy_o = (state_q == ST_INIT);

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the scheduler.
module tb_gpr_wb_arbiter;

  localparam int N    = 4;
  localparam int NW   = 4;
  localparam int NR   = 32;
  localparam int NT   = 4;
  localparam int DW   = 32;
  localparam int WIDW = 2;
  localparam int RIDW = 5;
  localparam int LDW  = NT * DW;
  localparam int WW   = 1 + WIDW + RIDW + NT + LDW;
  localparam int LAST = NW * NR - 1;

  logic                 clk;
  logic                 rst_ni;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N*WIDW-1:0]    req_wid;
  logic [N*RIDW-1:0]    req_rd;
  logic [N*NT-1:0]      req_tmask;
  logic [N*LDW-1:0]     req_data;
  logic                 wb_valid;
  logic                 wb_ready;
  logic [WIDW-1:0]      wb_wid;
  logic [RIDW-1:0]      wb_rd;
  logic [NT-1:0]        wb_tmask;
  logic [LDW-1:0]       wb_data;
  logic                 init_busy;

  logic [WIDW-1:0]      r_wid   [N];
  logic [RIDW-1:0]      r_rd    [N];
  logic [NT-1:0]        r_tmask [N];
  logic [LDW-1:0]       r_data  [N];

  // Behavioural model: output slot contents, init progress, rotation start.
  logic                 m_valid;
  logic [WIDW-1:0]      m_wid;
  logic [RIDW-1:0]      m_rd;
  logic [NT-1:0]        m_tmask;
  logic [LDW-1:0]       m_data;
  bit                   m_init;
  int                   m_cnt;
  int                   m_ptr;

  int n_tests;
  int n_fail;

  gpr_wb_arbiter #(
    .NUM_REQS(N), .NUM_WARPS(NW), .NUM_REGS(NR), .NUM_THREADS(NT), .DATAW(DW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_wid_i   (req_wid),
    .req_rd_i    (req_rd),
    .req_tmask_i (req_tmask),
    .req_data_i  (req_data),
    .wb_valid_o  (wb_valid),
    .wb_ready_i  (wb_ready),
    .wb_wid_o    (wb_wid),
    .wb_rd_o     (wb_rd),
    .wb_tmask_o  (wb_tmask),
    .wb_data_o   (wb_data),
    .init_busy_o (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_wid   = '0;
    req_rd    = '0;
    req_tmask = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) begin
      req_wid[i*WIDW +: WIDW] = r_wid[i];
      req_rd[i*RIDW +: RIDW]  = r_rd[i];
      req_tmask[i*NT +: NT]   = r_tmask[i];
      req_data[i*LDW +: LDW]  = r_data[i];
    end
  end

  // Rotate the request mask so ptr sits at bit 0, then take the lowest set bit.
  function automatic int pick(input logic [N-1:0] mask, input int ptr);
    logic [2*N-1:0] dbl;
    dbl = {mask, mask} >> ptr;
    for (int j = 0; j < N; j++) if (dbl[j]) return (ptr + j) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int w;
    r = '0;
    w = pick(req_valid, m_ptr);
    if (rst_ni && !m_init && (!m_valid || wb_ready) && w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  function automatic logic [WW-1:0] dut_word();
    if (wb_valid !== 1'b1) return {wb_valid, {(WW-1){1'b0}}};
    return {1'b1, wb_wid, wb_rd, wb_tmask, wb_data};
  endfunction

  function automatic logic [WW-1:0] model_word();
    if (!m_valid) return '0;
    return {1'b1, m_wid, m_rd, m_tmask, m_data};
  endfunction

  function automatic int model_addr();
    return int'(m_wid) * NR + int'(m_rd);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_wid = '0; m_rd = '0; m_tmask = '0; m_data = '0;
    m_init = 1'b1; m_cnt = 0; m_ptr = 0;
  endtask

  // Apply the upcoming clock edge to the model using the currently driven inputs.
  task automatic model_advance();
    int w;
    if (m_valid && !wb_ready) return;
    if (m_init) begin
      m_valid = 1'b1;
      m_wid   = WIDW'(m_cnt / NR);
      m_rd    = RIDW'(m_cnt % NR);
      m_tmask = '1;
      m_data  = '0;
      if (m_cnt == LAST) m_init = 1'b0;
      m_cnt++;
    end else begin
      w = pick(req_valid, m_ptr);
      if (w < 0) begin
        m_valid = 1'b0;
      end else begin
        m_valid = 1'b1;
        m_wid = r_wid[w]; m_rd = r_rd[w]; m_tmask = r_tmask[w]; m_data = r_data[w];
        m_ptr = (w + 1) % N;
      end
    end
  endtask

  task automatic randomize_reqs();
    for (int i = 0; i < N; i++) begin
      r_wid[i]   = WIDW'($urandom);
      r_rd[i]    = RIDW'($urandom);
      r_tmask[i] = NT'($urandom);
      for (int t = 0; t < NT; t++) r_data[i][t*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic clock_cycle();
    model_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; wb_ready = 1'b1; req_valid = '1;
    randomize_reqs();
    model_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", wb_valid); end
    n_tests++;
    if ({wb_wid, wb_rd, wb_tmask, wb_data} !== '0) begin
      n_fail++; $display("FAIL reset_fields: got %h want 0", {wb_wid, wb_rd, wb_tmask, wb_data});
    end
    n_tests++;
    if (req_ready !== '0) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_tests++;
    if (init_busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", init_busy); end
    rst_ni = 1'b1;
  endtask

  // Entered on the negedge right after reset release.
  task automatic test_init_sweep(input int stall_at, input int stall_len, input bit no_bubble);
    int stalled;
    int last_cyc;
    stalled = 0;
    last_cyc = -1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      randomize_reqs();
      req_valid = N'($urandom);
      wb_ready = 1'b1;
      if (m_valid && model_addr() == stall_at && stalled < stall_len) begin
        wb_ready = 1'b0;
        stalled++;
      end
      #1;
      n_tests++;
      if (req_ready !== exp_ready()) begin
        n_fail++; $display("FAIL init_ready cyc %0d: got %b want %b", cyc, req_ready, exp_ready());
      end
      clock_cycle();
      n_tests++;
      if (dut_word() !== model_word()) begin
        n_fail++; $display("FAIL init_entry cyc %0d: got %h want %h", cyc, dut_word(), model_word());
      end
      n_tests++;
      if (init_busy !== m_init) begin
        n_fail++; $display("FAIL init_busy cyc %0d: got %b want %b", cyc, init_busy, m_init);
      end
      if (cyc == 1) begin
        n_tests++;
        if ({wb_valid, wb_wid, wb_rd} !== {1'b1, {(WIDW+RIDW){1'b0}}}) begin
          n_fail++; $display("FAIL init_first: got v=%b addr=%0d want v=1 addr=0", wb_valid, {wb_wid, wb_rd});
        end
      end
      if (wb_valid === 1'b1 && {wb_wid, wb_rd} === (WIDW+RIDW)'(LAST)) begin
        last_cyc = cyc;
        break;
      end
    end
    n_tests++;
    if (last_cyc != LAST + 1 + stall_len) begin
      n_fail++; $display("FAIL init_length: got %0d want %0d", last_cyc, LAST + 1 + stall_len);
    end
    n_tests++;
    if (init_busy !== 1'b0) begin n_fail++; $display("FAIL init_busy_last: got %b want 0", init_busy); end
    wb_ready = 1'b1;
    if (no_bubble) begin
      randomize_reqs();
      req_valid = 4'b1000;
      #1;
      n_tests++;
      if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL no_bubble_ready: got %b want 1000", req_ready); end
      clock_cycle();
      n_tests++;
      if ({wb_valid, wb_data} !== {1'b1, r_data[3]}) begin
        n_fail++; $display("FAIL no_bubble_data: got %h want %h", {wb_valid, wb_data}, {1'b1, r_data[3]});
      end
    end
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    int exp_order [6] = '{0, 1, 2, 3, 0, 1};
    logic [N-1:0] onehot;
    randomize_reqs();
    for (int k = 0; k < 6; k++) begin
      req_valid = '1; wb_ready = 1'b1;
      #1;
      onehot = '0;
      onehot[exp_order[k]] = 1'b1;
      n_tests++;
      if (req_ready !== onehot) begin n_fail++; $display("FAIL rr_grant %0d: got %b want %b", k, req_ready, onehot); end
      clock_cycle();
      n_tests++;
      if ({wb_valid, wb_data} !== {1'b1, r_data[exp_order[k]]}) begin
        n_fail++; $display("FAIL rr_data %0d: got %h want %h", k, {wb_valid, wb_data}, {1'b1, r_data[exp_order[k]]});
      end
    end
    req_valid = '0;
  endtask

  task automatic test_sparse_fairness();
    logic [N-1:0] masks [8] = '{4'b1000, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0010, 4'b0010, 4'b0010};
    int exp_w [8] = '{3, 1, 3, 1, 3, 1, 1, 1};
    logic [N-1:0] onehot;
    for (int k = 0; k < 8; k++) begin
      randomize_reqs();
      req_valid = masks[k]; wb_ready = 1'b1;
      #1;
      onehot = '0;
      onehot[exp_w[k]] = 1'b1;
      n_tests++;
      if (req_ready !== onehot) begin n_fail++; $display("FAIL sparse_grant %0d: got %b want %b", k, req_ready, onehot); end
      clock_cycle();
      n_tests++;
      if ({wb_valid, wb_data} !== {1'b1, r_data[exp_w[k]]}) begin
        n_fail++; $display("FAIL sparse_data %0d: got %h want %h", k, {wb_valid, wb_data}, {1'b1, r_data[exp_w[k]]});
      end
    end
    req_valid = '0;
  endtask

  task automatic test_run_backpressure();
    randomize_reqs();
    req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      wb_ready = 1'b0;
      #1;
      n_tests++;
      if (req_ready !== '0) begin n_fail++; $display("FAIL bp_ready %0d: got %b want 0000", k, req_ready); end
      clock_cycle();
      n_tests++;
      if (dut_word() !== model_word() || wb_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold %0d: got %h want %h", k, dut_word(), model_word());
      end
    end
    wb_ready = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_release_ready: got %b want 0100", req_ready); end
    clock_cycle();
    n_tests++;
    if ({wb_valid, wb_data} !== {1'b1, r_data[2]}) begin
      n_fail++; $display("FAIL bp_release_data: got %h want %h", {wb_valid, wb_data}, {1'b1, r_data[2]});
    end
    req_valid = '0;
  endtask

  task automatic test_random_traffic();
    for (int k = 0; k < 500; k++) begin
      randomize_reqs();
      req_valid = N'($urandom);
      wb_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_tests++;
      if (req_ready !== exp_ready()) begin
        n_fail++; $display("FAIL rand_ready %0d: got %b want %b", k, req_ready, exp_ready());
      end
      clock_cycle();
      n_tests++;
      if (dut_word() !== model_word()) begin
        n_fail++; $display("FAIL rand_out %0d: got %h want %h", k, dut_word(), model_word());
      end
    end
    req_valid = '0; wb_ready = 1'b1;
  endtask

  task automatic test_midrun_reset();
    randomize_reqs();
    req_valid = 4'b0100; wb_ready = 1'b1;
    #1;
    model_advance();
    @(posedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    n_tests++;
    if ({wb_valid, wb_wid, wb_rd, wb_tmask, wb_data} !== '0) begin
      n_fail++; $display("FAIL midrst_clear: got %h want 0", {wb_valid, wb_wid, wb_rd, wb_tmask, wb_data});
    end
    n_tests++;
    if (init_busy !== 1'b1 || req_ready !== '0) begin
      n_fail++; $display("FAIL midrst_ctrl: got busy=%b ready=%b want busy=1 ready=0000", init_busy, req_ready);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    test_init_sweep(-1, 0, 1'b0);
    randomize_reqs();
    req_valid = '1; wb_ready = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL midrst_first_grant: got %b want 0001", req_ready); end
    clock_cycle();
    n_tests++;
    if ({wb_valid, wb_data} !== {1'b1, r_data[0]}) begin
      n_fail++; $display("FAIL midrst_first_data: got %h want %h", {wb_valid, wb_data}, {1'b1, r_data[0]});
    end
    req_valid = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_init_sweep(-1, 0, 1'b1);
    do_reset();
    test_init_sweep(40, 5, 1'b1);
    test_round_robin();
    test_sparse_fairness();
    test_run_backpressure();
    test_random_traffic();
    test_midrun_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
